// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Register stage that sits directly in front of the 8-bit ALU. It holds the
// accumulator (A) and the B operand, and feeds both registers to the ALU. It
// latches the ALU's overflow (carry) and zero outputs into a flags register,
// and drives either A or the ALU result onto the shared bus. It also decides
// conditional jumps for the control sequencer.
//
// Ports:
//   clk           system clock; all state updates on the rising edge
//   n_rst         synchronous active-low reset
//   bus_in        current value of the shared bus
//   ai / bi       load A / B from bus_in
//   ao / eo       drive A / ALU result onto the bus
//   su            subtract select (passed straight through to the ALU)
//   fi            latch ALU flags (carry <- overflow, zero <- zero)
//   clr           synchronous clear of A, B, flags and bus_conflict
//   jc_req/jz_req jump-if-carry / jump-if-zero requests
//   alu_result, alu_overflow, alu_zero   combinational ALU outputs
//   port_a, port_b, sub                  ALU operand and control inputs
//   bus_out, bus_out_en                  bus drive value and enable
//   flag_c, flag_z                       registered flags
//   jump_taken                           combinational jump decision
//   bus_conflict                         sticky "ao and eo together" error
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ai,
    input  logic             bi,
    input  logic             ao,
    input  logic             eo,
    input  logic             su,
    input  logic             fi,
    input  logic             clr,
    input  logic             jc_req,
    input  logic             jz_req,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] port_a,
    output logic [WIDTH-1:0] port_b,
    output logic             sub,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_out_en,
    output logic             flag_c,
    output logic             flag_z,
    output logic             jump_taken,
    output logic             bus_conflict
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_flag_c;
    logic             r_flag_z;
    logic             r_conflict;

    logic [WIDTH-1:0] w_bus_out;

    // Reset outranks clr, which outranks every load. The flags are taken
    // from the ALU outputs before the edge, so fi together with ai latches
    // flags computed from the old A.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_conflict <= 1'b0;
        end else if (clr) begin
            r_a        <= '0;
            r_b        <= '0;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (ai) begin
                r_a <= bus_in;
            end
            if (bi) begin
                r_b <= bus_in;
            end
            if (fi) begin
                r_flag_c <= alu_overflow;
                r_flag_z <= alu_zero;
            end
            // Sticky: once two drivers have fought over the bus, the flag
            // stays set until software clears it.
            if (ao && eo) begin
                r_conflict <= 1'b1;
            end
        end
    end

    // Bus mux, one bit at a time: A wins over the ALU result when both
    // drivers are asserted, and an idle block drives zero.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus_bit
            assign w_bus_out[gi] = ao ? r_a[gi] : (eo & alu_result[gi]);
        end
    endgenerate

    assign port_a       = r_a;
    assign port_b       = r_b;
    assign sub          = su;
    assign bus_out      = w_bus_out;
    assign bus_out_en   = ao | eo;
    assign flag_c       = r_flag_c;
    assign flag_z       = r_flag_z;
    // Only the registered flags are used here, never the live ALU outputs,
    // so the decision is stable for the whole cycle.
    assign jump_taken   = (jc_req & r_flag_c) | (jz_req & r_flag_z);
    assign bus_conflict = r_conflict;

endmodule
